// File: rtl/qspi_sio_sequencer_pkg.sv
// Shared types and defaults for the quad-SPI pin-bus sequencer.
package qspi_seq_pkg;

  localparam int unsigned DEF_LEN_W  = 8;
  localparam int unsigned DEF_DATA_W = 4;

  // Output-enable pattern used while the sequencer owns the pins.
  localparam logic [DEF_DATA_W-1:0] OE_ALL = '1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    TURN,
    READ,
    DONE
  } seq_state_t;

endpackage

// File: rtl/qspi_sio_sequencer_if.sv
// Command-engine / pad-side signal bundle of the quad-SPI sequencer.
// The slave modport is the sequencer; master is the command engine plus pads.
interface qspi_sio_sequencer_if #(
  parameter int unsigned LEN_W  = qspi_seq_pkg::DEF_LEN_W,
  parameter int unsigned DATA_W = qspi_seq_pkg::DEF_DATA_W
);

  logic              start;
  logic [LEN_W-1:0]  wr_len;
  logic [LEN_W-1:0]  dummy_len;
  logic [LEN_W-1:0]  rd_len;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ready;
  logic [DATA_W-1:0] sio_o;
  logic [DATA_W-1:0] sio_oe;
  logic [DATA_W-1:0] sio_i;
  logic              sck_en;
  logic              busy;
  logic              done;

  modport slave (
    input  start, wr_len, dummy_len, rd_len,
    input  tx_valid, tx_data, rx_ready, sio_i,
    output tx_ready, rx_valid, rx_data,
    output sio_o, sio_oe, sck_en, busy, done
  );

  modport master (
    output start, wr_len, dummy_len, rd_len,
    output tx_valid, tx_data, rx_ready, sio_i,
    input  tx_ready, rx_valid, rx_data,
    input  sio_o, sio_oe, sck_en, busy, done
  );

endinterface

// File: rtl/qspi_sio_sequencer_phase_counter.sv
// Phase length down-counter: load, decrement on each advance, flag the last one.
module qspi_phase_counter
  import qspi_seq_pkg::*;
#(
  parameter int unsigned LEN_W = DEF_LEN_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [LEN_W-1:0] count_q;

  // Load on transaction accept; decrement saturates at zero instead of wrapping.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - LEN_W'(1);
    end
  end

  // An advance taken while this is high is the final one of the phase.
  assign last = (count_q == LEN_W'(1));

endmodule

// File: rtl/qspi_sio_sequencer.sv
// Quad-SPI pin-bus sequencer: write phase, turnaround, read phase.
// Produces sio_o/sio_oe and samples sio_i; tristate muxing lives at top level.
module qspi_sio_sequencer
  import qspi_seq_pkg::*;
#(
  parameter int unsigned LEN_W  = DEF_LEN_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input logic                 sys_clk,
  input logic                 sys_rst_n,
  qspi_sio_sequencer_if.slave bus
);

  localparam logic [DATA_W-1:0] OE_ON = '1;

  seq_state_t       state_q, state_d;
  logic             accept;
  logic             wr_adv, turn_adv, rd_adv;
  logic             wr_last, turn_last, rd_last;
  logic             rd_pending_q;
  logic [LEN_W-1:0] turn_load;

  // The done cycle is already IDLE; gating on done makes the next cycle the
  // earliest one that can accept a new start.
  assign accept    = (state_q == IDLE) && bus.start && !bus.done;
  assign wr_adv    = (state_q == WRITE) && bus.tx_valid;
  assign turn_adv  = (state_q == TURN);
  assign rd_adv    = (state_q == READ) && (!bus.rx_valid || bus.rx_ready);
  // At least one high-Z cycle always separates drive from sample.
  assign turn_load = (bus.dummy_len == '0) ? LEN_W'(1) : bus.dummy_len;

  qspi_phase_counter #(.LEN_W(LEN_W)) u_wr_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (accept),
    .load_val  (bus.wr_len),
    .dec       (wr_adv),
    .last      (wr_last)
  );

  qspi_phase_counter #(.LEN_W(LEN_W)) u_turn_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (accept),
    .load_val  (turn_load),
    .dec       (turn_adv),
    .last      (turn_last)
  );

  qspi_phase_counter #(.LEN_W(LEN_W)) u_rd_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (accept),
    .load_val  (bus.rd_len),
    .dec       (rd_adv),
    .last      (rd_last)
  );

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection plus the combinational handshake/clock-gate outputs.
  always_comb begin
    state_d      = state_q;
    bus.tx_ready = 1'b0;
    bus.sck_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.wr_len != '0) begin
            state_d = WRITE;
          end else if (bus.rd_len != '0) begin
            state_d = TURN;
          end else begin
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        bus.tx_ready = wr_adv;
        bus.sck_en   = wr_adv;
        if (wr_adv && wr_last) begin
          state_d = rd_pending_q ? TURN : DONE;
        end
      end
      TURN: begin
        bus.sck_en = 1'b1;
        if (turn_last) begin
          state_d = READ;
        end
      end
      READ: begin
        bus.sck_en = rd_adv;
        if (rd_adv && rd_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!bus.rx_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered pin, read-data and status outputs.
  // sio_oe drops on the last write advance so the first TURN cycle is undriven.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bus.sio_o    <= '0;
      bus.sio_oe   <= '0;
      bus.rx_valid <= 1'b0;
      bus.rx_data  <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      rd_pending_q <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        bus.busy     <= 1'b1;
        rd_pending_q <= (bus.rd_len != '0);
        bus.sio_oe   <= (bus.wr_len != '0) ? OE_ON : '0;
      end
      if (wr_adv) begin
        bus.sio_o <= bus.tx_data;
        if (wr_last) begin
          bus.sio_oe <= '0;
        end
      end
      if (rd_adv) begin
        bus.rx_data  <= bus.sio_i;
        bus.rx_valid <= 1'b1;
      end else if (bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end
      if ((state_q == DONE) && !bus.rx_valid) begin
        bus.done <= 1'b1;
        bus.busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qspi_sio_sequencer.sv
// Directed bench for qspi_sio_sequencer: table of transactions plus
// hand-written reset-abort and start-on-done sequences.
module tb_qspi_sio_sequencer;
  import qspi_seq_pkg::*;

  logic sys_clk = 1'b0;
  logic sys_rst_n;

  always #5 sys_clk = ~sys_clk;

  qspi_sio_sequencer_if #(.LEN_W(8), .DATA_W(4)) bus ();

  qspi_sio_sequencer #(.LEN_W(8), .DATA_W(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  typedef struct packed {
    logic [7:0]  wr;
    logic [7:0]  dm;
    logic [7:0]  rd;
    logic [15:0] tx_pat;     // nibble k = k-th write nibble
    logic [15:0] rx_pat;     // nibble k = k-th nibble presented on sio_i
    int          gap_at;     // tx_valid low while this many nibbles sent
    int          gap_len;
    int          stall_at;   // rx_ready low while this many nibbles received
    int          stall_len;
    int          extra_start;// cycle of a second (ignored) start, -1 none
    int          exp_sck;
    int          exp_txr;
    int          exp_done;   // cycle index (start cycle = 0) where done is high
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  int n_vec = 0;
  int n_bad = 0;
  logic [3:0] last_tx = 4'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.wr_len    = 8'd0;
    bus.dummy_len = 8'd0;
    bus.rd_len    = 8'd0;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = 4'h0;
    bus.rx_ready  = 1'b1;
    bus.sio_i     = 4'h0;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int sck = 0;
    int txc = 0;
    int rxc = 0;
    int gap_left;
    int stall_left;
    int turn;
    int idx;
    logic prev_stall = 1'b0;
    logic [3:0] prev_data = 4'h0;
    logic [3:0] nib;
    string tag;
    gap_left   = v.gap_len;
    stall_left = v.stall_len;
    turn = (v.rd != 8'd0) ? ((v.dm == 8'd0) ? 1 : int'(v.dm)) : 0;
    for (int c = 0; c <= v.exp_done + 1; c++) begin
      @(negedge sys_clk);
      bus.start = (c == 0) || (c == v.extra_start);
      if (c == 0) begin
        bus.wr_len = v.wr; bus.dummy_len = v.dm; bus.rd_len = v.rd;
      end else if (c == v.extra_start) begin
        bus.wr_len = 8'd7; bus.dummy_len = 8'd7; bus.rd_len = 8'd7;
      end
      if ((txc == v.gap_at) && (gap_left > 0)) begin
        bus.tx_valid = 1'b0;
        gap_left--;
      end else begin
        bus.tx_valid = 1'b1;
      end
      bus.tx_data = (txc < int'(v.wr) && txc < 4) ? v.tx_pat[txc*4 +: 4] : 4'h0;
      idx = sck - int'(v.wr) - turn;
      bus.sio_i = (idx >= 0 && idx < int'(v.rd) && idx < 4) ? v.rx_pat[idx*4 +: 4] : 4'h0;
      if (bus.rx_valid && (rxc == v.stall_at) && (stall_left > 0)) begin
        bus.rx_ready = 1'b0;
        stall_left--;
      end else begin
        bus.rx_ready = 1'b1;
      end
      #1;
      tag = $sformatf("v%0d c%0d", id, c);
      chk({tag, " sio_oe"}, 32'(bus.sio_oe),
          (c >= 1 && txc < int'(v.wr)) ? 32'(OE_ALL) : 32'h0);
      chk({tag, " sio_o"}, 32'(bus.sio_o), 32'(last_tx));
      chk({tag, " busy"}, 32'(bus.busy), 32'(c >= 1 && c < v.exp_done));
      chk({tag, " done"}, 32'(bus.done), 32'(c == v.exp_done));
      if (prev_stall) begin
        chk({tag, " rx_hold"}, 32'({bus.rx_valid, bus.rx_data}), 32'({1'b1, prev_data}));
      end
      if (bus.rx_valid && !bus.rx_ready) begin
        chk({tag, " stall_sck"}, 32'(bus.sck_en), 32'h0);
      end
      prev_stall = bus.rx_valid && !bus.rx_ready;
      prev_data  = bus.rx_data;
      if (bus.sck_en) sck++;
      if (bus.tx_ready) begin
        last_tx = bus.tx_data;
        txc++;
      end
      if (bus.rx_valid && bus.rx_ready) begin
        nib = (rxc < 4) ? v.rx_pat[rxc*4 +: 4] : 4'h0;
        chk($sformatf("v%0d rx%0d", id, rxc), 32'(bus.rx_data), 32'(nib));
        rxc++;
      end
    end
    chk($sformatf("v%0d sck_count", id), 32'(sck), 32'(v.exp_sck));
    chk($sformatf("v%0d tx_ready_count", id), 32'(txc), 32'(v.exp_txr));
    chk($sformatf("v%0d rx_count", id), 32'(rxc), 32'(v.rd));
    // Resynchronise after a misbehaving DUT so later vectors stay meaningful.
    for (int w = 0; w < 100 && bus.busy; w++) @(negedge sys_clk);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            wr    dm    rd    tx_pat    rx_pat  gap   glen stall slen xs  sck txr done
    vecs[0] = '{8'd2, 8'd0, 8'd2, 16'h005A, 16'h00C3, 0, 0, 0, 0, -1, 5, 2, 8};
    vecs[1] = '{8'd1, 8'd0, 8'd0, 16'h0009, 16'h0000, 0, 0, 0, 0, -1, 1, 1, 3};
    vecs[2] = '{8'd3, 8'd2, 8'd1, 16'h0321, 16'h0006, 1, 2, 0, 0, -1, 6, 3, 11};
    vecs[3] = '{8'd0, 8'd0, 8'd3, 16'h0000, 16'h0987, 0, 0, 0, 4, -1, 4, 0, 11};
    vecs[4] = '{8'd0, 8'd0, 8'd0, 16'h0000, 16'h0000, 0, 0, 0, 0, -1, 0, 0, 2};
    vecs[5] = '{8'd1, 8'd3, 8'd1, 16'h000E, 16'h000B, 0, 0, 0, 0, -1, 5, 1, 8};
    vecs[6] = '{8'd2, 8'd0, 8'd0, 16'h00D4, 16'h0000, 0, 0, 0, 0, 1, 2, 2, 4};

    idle_inputs();
    sys_rst_n = 1'b1;
    #2 sys_rst_n = 1'b0;
    #2;
    chk("reset sio_oe", 32'(bus.sio_oe), 32'h0);
    chk("reset sio_o", 32'(bus.sio_o), 32'h0);
    chk("reset outs", 32'({bus.tx_ready, bus.rx_valid, bus.sck_en, bus.busy, bus.done}), 32'h0);
    chk("reset rx_data", 32'(bus.rx_data), 32'h0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    last_tx = 4'h0;

    for (int i = 0; i < NV; i++) begin
      run_vec(i, vecs[i]);
    end

    // Start presented on the done cycle is ignored; the next cycle's is taken.
    @(negedge sys_clk);
    bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    @(negedge sys_clk);
    #1;
    chk("sod done", 32'(bus.done), 32'h1);
    bus.start = 1'b1;
    @(negedge sys_clk);
    #1;
    chk("sod ignored busy", 32'(bus.busy), 32'h0);
    @(negedge sys_clk);
    bus.start = 1'b0;
    #1;
    chk("sod accepted busy", 32'(bus.busy), 32'h1);
    @(negedge sys_clk);
    #1;
    chk("sod second done", 32'(bus.done), 32'h1);
    chk("sod second busy", 32'(bus.busy), 32'h0);

    // Asynchronous reset in the middle of a 4-nibble write.
    @(negedge sys_clk);
    bus.start = 1'b1; bus.wr_len = 8'd4; bus.dummy_len = 8'd0; bus.rd_len = 8'd0;
    bus.tx_valid = 1'b1; bus.tx_data = 4'h6;
    @(negedge sys_clk);
    bus.start = 1'b0;
    #1;
    chk("rst pre oe", 32'(bus.sio_oe), 32'(OE_ALL));
    @(negedge sys_clk);
    #1;
    chk("rst pre sio_o", 32'(bus.sio_o), 32'h6);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst async oe", 32'(bus.sio_oe), 32'h0);
    chk("rst async busy", 32'(bus.busy), 32'h0);
    chk("rst async sio_o", 32'(bus.sio_o), 32'h0);
    chk("rst async comb", 32'({bus.sck_en, bus.tx_ready}), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clk);
      #1;
      chk($sformatf("rst hold %0d done", k), 32'(bus.done), 32'h0);
    end
    idle_inputs();
    sys_rst_n = 1'b1;
    last_tx = 4'h0;
    run_vec(7, vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/qspi_sio_sequencer.md
Name: qspi_sio_sequencer

Overview:
- Sequences one transaction on a 4-bit bidirectional quad-SPI pin bus (sio[3:0]): a write phase, then turnaround/dummy cycles, then a read phase.
- Sits between a command engine and the top-level tristate pads.
- Owns every output-enable decision, so the pads are never driven during turnaround.
- Pad muxing (drive when oe, else Z) stays at top level; this block only produces o/oe and consumes i.

Parameters:
LEN_W, 8, width of each phase-length field (max phase length 2^LEN_W-1 nibbles/cycles)
DATA_W, 4, pin-bus width (one nibble per active cycle)

Ports:
sys_clk  in  1  sole clock
sys_rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; accepted only when busy=0
wr_len  in  LEN_W  nibbles to drive; captured on accepted start
dummy_len  in  LEN_W  turnaround/dummy cycles; captured on accepted start
rd_len  in  LEN_W  nibbles to sample; captured on accepted start
tx_valid  in  1  write nibble available
tx_data  in  DATA_W  write nibble
tx_ready  out  1  tx_data consumed this cycle
rx_valid  out  1  read nibble available (registered)
rx_data  out  DATA_W  read nibble
rx_ready  in  1  consumer accepts rx_data
sio_o  out  DATA_W  pad output value
sio_oe  out  DATA_W  pad output enable (all bits equal)
sio_i  in  DATA_W  pad input value
sck_en  out  1  high on every cycle that advances the bus (SPI clock gate)
busy  out  1  transaction in progress
done  out  1  one-cycle pulse at end of transaction

Behaviour:
- Reset (async, sys_rst_n=0): state IDLE; sio_oe=0 immediately; sio_o=0, tx_ready=0, rx_valid=0, rx_data=0, sck_en=0, busy=0, done=0; counters cleared. Reset mid-transaction aborts with no done pulse.
- States: IDLE, WRITE, TURN, READ, DONE. All outputs registered except tx_ready and sck_en, which are combinational from state and handshakes.
- IDLE: on start, latch the three lengths and set busy=1 next cycle. Next state is the first applicable of:
  - WRITE if wr_len>0
  - TURN if rd_len>0
  - DONE otherwise
- start while busy=1 is ignored.
- WRITE: sio_oe=all-ones.
  - Advance cycle: tx_valid=1. Then tx_ready=1, sck_en=1, and sio_o<=tx_data (visible next cycle).
  - tx_valid=0 stalls: sck_en=0; sio_o and sio_oe hold.
  - Leave after wr_len advances: go to TURN if rd_len>0, else DONE.
- TURN: sio_oe=0 on the first TURN cycle; sck_en=1 every cycle.
  - Lasts max(dummy_len,1) cycles, so at least one high-Z cycle always separates drive and sample.
  - Then go to READ.
- READ: sio_oe=0.
  - Advance cycle: rx_valid=0 or rx_ready=1. Then sck_en=1, rx_data<=sio_i, rx_valid<=1.
  - rx_valid=1 with rx_ready=0 stalls: sck_en=0, no sample.
  - rx_valid clears when rx_ready=1 and no new sample is taken.
  - Leave after rd_len samples, to DONE.
- DONE: waits until rx_valid=0 (last nibble consumed), then pulses done=1 for one cycle, sets busy=0 and returns to IDLE; sio_oe stays 0. A start on the done cycle is ignored; the earliest accepted start is the following cycle.
- Counters: LEN_W-bit down-counters loaded from the captured lengths; no wrap (terminal at 1→0 triggers the transition).
- Invariant: sio_oe=1 only in WRITE; never 1 in the cycle after a sio_i sample.

Decomposition:
- Package qspi_seq_pkg: state enum (IDLE, WRITE, TURN, READ, DONE), LEN_W/DATA_W defaults, OE_ALL constant.
- One sub-module: qspi_phase_counter (load / decrement-on-advance / terminal flag), instantiated per phase or shared.

Test Plan:
1. wr_len=2, dummy_len=0, rd_len=2; tx=0xA,0x5 always valid; sio_i=0x3 then 0xC; rx_ready=1 -> sio_o shows A then 5 with sio_oe=F; exactly 1 TURN cycle with oe=0; rx_data 3 then C; done one cycle after the last rx_valid clears; total sck_en count 5.
2. wr_len=1, dummy_len=0, rd_len=0 -> no TURN/READ; sio_oe=0 after the write; done pulses; sck_en count 1.
3. wr_len=3 with tx_valid low for 2 cycles mid-phase -> sck_en=0 and sio_o held during the gap; 3 tx_ready pulses total.
4. rd_len=3, rx_ready held low 4 cycles after the first sample -> rx_data stable, no further sck_en until accepted; all 3 nibbles delivered in order.
5. All lengths 0 -> IDLE→DONE; done pulses 2 cycles after start; sck_en never asserted.
6. sys_rst_n low during the WRITE of wr_len=4 -> sio_oe=0 in the same cycle (async); busy=0; no done; a new start after release works normally.
